viterbi_traceback_out: RTL

//  Output stage directly downstream of the four ACS_mem lanes of the 4-state Viterbi decoder.

---
 rtl/viterbi_pkg.sv | 38 +++
 rtl/viterbi_traceback_out_if.sv | 32 +++
 rtl/viterbi_bit_fifo.sv | 56 +++++
 rtl/viterbi_traceback_out.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the 4-state Viterbi traceback output stage.
// Contents: state-count/width constants, packed PM and survivor vectors,
// the traceback FSM state enum and the argmin-over-path-metrics function.
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int PM_W       = 7;
  localparam int TB_DEPTH   = 8;
  localparam int IDX_W      = $clog2(NUM_STATES);
  localparam int TB_IDX_W   = $clog2(TB_DEPTH);
  // One extra bit so the counters can hold TB_DEPTH itself if ever needed.
  localparam int CNT_W      = TB_IDX_W + 1;

  typedef logic [NUM_STATES-1:0][PM_W-1:0]     pm_vec_t;
  typedef logic [NUM_STATES-1:0][TB_DEPTH-1:0] data_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } tb_state_t;

  // Index of the smallest unsigned PM; strict '<' keeps ties on the lowest index.
  function automatic logic [IDX_W-1:0] argmin_pm(input pm_vec_t pm);
    logic [IDX_W-1:0] best;
    best = IDX_W'(0);
    for (int i = 1; i < NUM_STATES; i++) begin
      if (pm[i] < pm[best]) begin
        best = IDX_W'(i);
      end else begin
        best = best;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/viterbi_traceback_out_if.sv
// Bus bundle between the ACS lanes, the traceback output stage and the
// decoded-bit consumer.
//   in_valid/in_ready/flush/pm/data : symbol input side
//   out_valid/out_ready/out_bit/out_last : decoded bit stream
//   norm_en/norm_val : path-metric normalisation request back to the ACS
// slave = the traceback stage, master = its environment.
interface viterbi_traceback_out_if;
  import viterbi_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic            flush;
  pm_vec_t         pm;
  data_vec_t       data;
  logic            out_valid;
  logic            out_ready;
  logic            out_bit;
  logic            out_last;
  logic            norm_en;
  logic [PM_W-1:0] norm_val;

  modport slave (
    input  in_valid, flush, pm, data, out_ready,
    output in_ready, out_valid, out_bit, out_last, norm_en, norm_val
  );

  modport master (
    output in_valid, flush, pm, data, out_ready,
    input  in_ready, out_valid, out_bit, out_last, norm_en, norm_val
  );

endinterface

// File: rtl/viterbi_bit_fifo.sv
// Small synchronous FIFO for decoded {bit,last} entries.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_wdata, i_pop,
//        o_rdata (head entry, zero when empty), o_full, o_empty.
module viterbi_bit_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_full;
  logic             w_empty;

  // Pointers carry a wrap bit: equal -> empty, only wrap bit differs -> full.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Pointer update; push while full and pop while empty are ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= (AW+1)'(0);
      r_rptr <= (AW+1)'(0);
    end else begin
      if (i_push && !w_full) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (i_pop && !w_empty) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge i_clk) begin
    if (i_push && !w_full) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = w_empty ? {WIDTH{1'b0}} : r_mem[r_rptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/viterbi_traceback_out.sv
// Traceback output stage of the 4-state Viterbi decoder.
// Per accepted symbol it picks the lowest-PM survivor and, once the survivor
// registers are full, emits its oldest bit into a {bit,last} FIFO. On flush it
// drains the remaining decided bits of the best survivor, tagging the final one.
// It also requests PM normalisation once the minimum PM reaches NORM_THR.
// Ports: i_clk, i_rst (sync, active-high), if_bus (slave modport of
//        viterbi_traceback_out_if).
module viterbi_traceback_out
  import viterbi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NORM_THR   = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  viterbi_traceback_out_if.slave         if_bus
);

  tb_state_t          r_state;
  tb_state_t          w_state_nxt;
  logic [CNT_W-1:0]   r_fill_cnt;
  logic [CNT_W-1:0]   w_fill_nxt;
  logic [CNT_W-1:0]   r_rem;
  logic [CNT_W-1:0]   w_rem_nxt;
  logic [TB_DEPTH-1:0] r_snap;
  logic [TB_DEPTH-1:0] w_snap_nxt;
  logic [TB_DEPTH-1:0] r_last_surv;
  logic               r_norm_en;
  logic [PM_W-1:0]    r_norm_val;
  logic [1:0]         r_hold;

  logic               w_accept;
  logic [IDX_W-1:0]   w_best_idx;
  logic [PM_W-1:0]    w_best_pm;
  logic [TB_DEPTH-1:0] w_best_surv;
  logic [TB_IDX_W-1:0] w_rem_idx;
  logic               w_push;
  logic               w_push_bit;
  logic               w_push_last;
  logic               w_pop;
  logic [1:0]         w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_norm_trig;

  assign w_best_idx  = argmin_pm(if_bus.pm);
  assign w_best_pm   = if_bus.pm[w_best_idx];
  assign w_best_surv = if_bus.data[w_best_idx];
  assign w_accept    = if_bus.in_valid && if_bus.in_ready;
  assign w_pop       = if_bus.out_valid && if_bus.out_ready;
  assign w_rem_idx   = TB_IDX_W'(r_rem - CNT_W'(1));
  assign w_norm_trig = w_accept && (w_best_pm >= PM_W'(NORM_THR));

  // Next-state, counter and FIFO-push decode for the traceback FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_rem_nxt   = r_rem;
    w_snap_nxt  = r_snap;
    w_push      = 1'b0;
    w_push_bit  = 1'b0;
    w_push_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = FILL;
          w_fill_nxt  = CNT_W'(1);
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FILL, STREAM: begin
        if (w_accept) begin
          if ((r_state == STREAM) || (r_fill_cnt == CNT_W'(TB_DEPTH - 1))) begin
            w_state_nxt = STREAM;
            w_fill_nxt  = CNT_W'(TB_DEPTH - 1);
            w_push      = 1'b1;
            w_push_bit  = w_best_surv[TB_DEPTH-1];
          end else begin
            w_fill_nxt  = r_fill_cnt + CNT_W'(1);
          end
        end else begin
          w_fill_nxt = r_fill_cnt;
        end
        // A same-cycle accept is included: snapshot the fresh survivor.
        if (if_bus.flush && (w_fill_nxt != CNT_W'(0))) begin
          w_state_nxt = FLUSH;
          w_rem_nxt   = w_fill_nxt;
          w_snap_nxt  = w_accept ? w_best_surv : r_last_surv;
        end else begin
          w_rem_nxt = r_rem;
        end
      end
      FLUSH: begin
        if (r_rem == CNT_W'(0)) begin
          w_state_nxt = IDLE;
          w_fill_nxt  = CNT_W'(0);
        end else if (!w_fifo_full) begin
          w_push      = 1'b1;
          w_push_bit  = r_snap[w_rem_idx];
          w_rem_nxt   = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_push_last = 1'b1;
            w_state_nxt = IDLE;
            w_fill_nxt  = CNT_W'(0);
          end else begin
            w_push_last = 1'b0;
          end
        end else begin
          w_push = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_fill_nxt  = CNT_W'(0);
      end
    endcase
  end

  // FSM state, counters, flush snapshot and last accepted best survivor.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_fill_cnt  <= CNT_W'(0);
      r_rem       <= CNT_W'(0);
      r_snap      <= TB_DEPTH'(0);
      r_last_surv <= TB_DEPTH'(0);
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_rem      <= w_rem_nxt;
      r_snap     <= w_snap_nxt;
      if (w_accept) begin
        r_last_surv <= w_best_surv;
      end
    end
  end

  // Normalisation pulse; r_hold blocks new pulses for two cycles after one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_norm_en  <= 1'b0;
      r_norm_val <= PM_W'(0);
      r_hold     <= 2'd0;
    end else if (w_norm_trig && (r_hold == 2'd0)) begin
      r_norm_en  <= 1'b1;
      r_norm_val <= w_best_pm;
      r_hold     <= 2'd2;
    end else begin
      r_norm_en <= 1'b0;
      if (r_hold != 2'd0) begin
        r_hold <= r_hold - 2'd1;
      end
    end
  end

  viterbi_bit_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata ({w_push_bit, w_push_last}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign if_bus.in_ready  = !w_fifo_full && (r_state != FLUSH);
  assign if_bus.out_valid = !w_fifo_empty;
  assign if_bus.out_bit   = w_fifo_rdata[1];
  assign if_bus.out_last  = w_fifo_rdata[0];
  assign if_bus.norm_en   = r_norm_en;
  assign if_bus.norm_val  = r_norm_val;

endmodule
